// File: rtl/player_move_animator.sv
`default_nettype none
// ============================================================================
// Module   : player_move_animator
// Purpose  : UI-side responder for the game controller's position handshake.
//            Steps the mover's displayed tile one square at a time toward its
//            committed position, then plays the landing event (move-back or
//            timed hold) and returns a single-cycle turn_done.
// Ports    :
//   clk           system clock (single domain)
//   reset_n       asynchronous active-low reset
//   pos_valid     controller level, high while a position update is pending
//   turn          mover identity (0 = player 1, 1 = player 2)
//   p1_pos/p2_pos committed positions
//   event_flag    landing event code (1 none, 2/4/6/8 hold, 3 back, 10 win)
//   winner_valid  game over
//   disp_p1_pos/disp_p2_pos  displayed positions for the renderer
//   turn_done     single-cycle completion pulse
//   anim_busy     high in every state except IDLE
//   anim_player   player latched for the current animation
//   debug_state   current state encoding
// Revision : 1.0 - initial release
// ============================================================================
module player_move_animator #(
  parameter int STEP_CYCLES       = 25_000_000,
  parameter int EVENT_HOLD_CYCLES = 50_000_000,
  parameter int MAX_POS           = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pos_valid,
  input  logic       turn,
  input  logic [3:0] p1_pos,
  input  logic [3:0] p2_pos,
  input  logic [3:0] event_flag,
  input  logic       winner_valid,
  output logic [3:0] disp_p1_pos,
  output logic [3:0] disp_p2_pos,
  output logic       turn_done,
  output logic       anim_busy,
  output logic       anim_player,
  output logic [2:0] debug_state
);

  localparam logic [31:0] c_step_last = 32'(STEP_CYCLES - 1);
  localparam logic [31:0] c_hold_last = 32'(EVENT_HOLD_CYCLES - 1);
  localparam logic [3:0]  c_max_pos   = 4'(MAX_POS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FWD_MOVE  = 3'd1,
    WAIT_DROP = 3'd2,
    EVT_MOVE  = 3'd3,
    EVT_HOLD  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        pv_dly_q, pv_dly_d;
  logic [31:0] step_cnt_q, step_cnt_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]  disp_p1_q, disp_p1_d;
  logic [3:0]  disp_p2_q, disp_p2_d;
  logic        anim_player_q, anim_player_d;
  logic        turn_done_q, turn_done_d;
  logic        anim_busy_q, anim_busy_d;

  logic [3:0]  clamp_p1;
  logic [3:0]  clamp_p2;
  logic [3:0]  target;
  logic [3:0]  cur_pos;
  logic [3:0]  step_pos;
  logic        pv_rise;
  logic        step_now;
  logic        no_event;

  function automatic logic [3:0] clamp_pos(input logic [3:0] p);
    return (p > c_max_pos) ? c_max_pos : p;
  endfunction

  always_comb begin
    clamp_p1 = clamp_pos(p1_pos);
    clamp_p2 = clamp_pos(p2_pos);
    target   = anim_player_q ? clamp_p2 : clamp_p1;
    cur_pos  = anim_player_q ? disp_p2_q : disp_p1_q;
    // Target is never negative, so a decrement never happens at tile 0.
    step_pos = (cur_pos < target) ? (cur_pos + 4'd1) : (cur_pos - 4'd1);
    pv_rise  = pos_valid & ~pv_dly_q;
    no_event = winner_valid || (event_flag == 4'd1) || (event_flag == 4'd10);
  end

  always_comb begin
    state_d       = state_q;
    pv_dly_d      = pos_valid;
    step_cnt_d    = step_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    disp_p1_d     = disp_p1_q;
    disp_p2_d     = disp_p2_q;
    anim_player_d = anim_player_q;
    turn_done_d   = 1'b0;
    step_now      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pv_rise) begin
          anim_player_d = turn;
          step_cnt_d    = 32'd0;
          state_d       = FWD_MOVE;
        end else begin
          // Resync only while no animation is being started: the committed
          // positions arrive together with the pos_valid rise, and copying
          // them in that cycle would make the mover jump to its target.
          disp_p1_d = clamp_p1;
          disp_p2_d = clamp_p2;
        end
      end

      FWD_MOVE, EVT_MOVE: begin
        if (cur_pos == target) begin
          turn_done_d = 1'b1;
          state_d     = (state_q == FWD_MOVE) ? WAIT_DROP : IDLE;
        end else if (step_cnt_q == c_step_last) begin
          step_cnt_d = 32'd0;
          step_now   = 1'b1;
        end else begin
          step_cnt_d = step_cnt_q + 32'd1;
        end
      end

      WAIT_DROP: begin
        // When pos_valid is seen low the event and positions already hold
        // the controller's post-landing values.
        if (!pos_valid) begin
          if (no_event) begin
            state_d = IDLE;
          end else if (cur_pos != target) begin
            step_cnt_d = 32'd0;
            state_d    = EVT_MOVE;
          end else begin
            hold_cnt_d = 32'd0;
            state_d    = EVT_HOLD;
          end
        end
      end

      EVT_HOLD: begin
        if (hold_cnt_q == c_hold_last) begin
          turn_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (step_now) begin
      if (anim_player_q) begin
        disp_p2_d = step_pos;
      end else begin
        disp_p1_d = step_pos;
      end
    end

    anim_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      // Reset high so a pos_valid already high at release is not taken as a
      // new update; a real fall and rise is required to start an animation.
      pv_dly_q      <= 1'b1;
      step_cnt_q    <= 32'd0;
      hold_cnt_q    <= 32'd0;
      disp_p1_q     <= 4'd0;
      disp_p2_q     <= 4'd0;
      anim_player_q <= 1'b0;
      turn_done_q   <= 1'b0;
      anim_busy_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pv_dly_q      <= pv_dly_d;
      step_cnt_q    <= step_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      disp_p1_q     <= disp_p1_d;
      disp_p2_q     <= disp_p2_d;
      anim_player_q <= anim_player_d;
      turn_done_q   <= turn_done_d;
      anim_busy_q   <= anim_busy_d;
    end
  end

  assign disp_p1_pos = disp_p1_q;
  assign disp_p2_pos = disp_p2_q;
  assign turn_done   = turn_done_q;
  assign anim_busy   = anim_busy_q;
  assign anim_player = anim_player_q;
  assign debug_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_player_move_animator.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_move_animator
// Purpose  : Self-checking bench for player_move_animator. Expected turn_done
//            cycles are queued as stimulus is driven and matched by a monitor;
//            displayed positions and state are compared inline per scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_player_move_animator;

  localparam int S  = 4;
  localparam int H  = 8;
  localparam int MP = 10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pos_valid;
  logic       turn;
  logic [3:0] p1_pos;
  logic [3:0] p2_pos;
  logic [3:0] event_flag;
  logic       winner_valid;
  logic [3:0] disp_p1_pos;
  logic [3:0] disp_p2_pos;
  logic       turn_done;
  logic       anim_busy;
  logic       anim_player;
  logic [2:0] debug_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_q[$];

  player_move_animator #(
    .STEP_CYCLES      (S),
    .EVENT_HOLD_CYCLES(H),
    .MAX_POS          (MP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pos_valid   (pos_valid),
    .turn        (turn),
    .p1_pos      (p1_pos),
    .p2_pos      (p2_pos),
    .event_flag  (event_flag),
    .winner_valid(winner_valid),
    .disp_p1_pos (disp_p1_pos),
    .disp_p2_pos (disp_p2_pos),
    .turn_done   (turn_done),
    .anim_busy   (anim_busy),
    .anim_player (anim_player),
    .debug_state (debug_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for turn_done: every pulse must match the queued cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0] == cyc) begin
      total++;
      if (turn_done !== 1'b1) begin
        bad++;
        $display("FAIL turn_done_missing: cycle %0d got %b want 1", cyc, turn_done);
      end
      void'(exp_q.pop_front());
    end else if (turn_done !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL turn_done_stray: cycle %0d got %b want 0", cyc, turn_done);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  // Advance to the negedge of cycle c (at least one negedge).
  task automatic at_neg(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic drive_rise(input logic who, input logic [3:0] np1,
                            input logic [3:0] np2, output int t0);
    @(posedge clk);
    #1;
    turn         = who;
    p1_pos       = np1;
    p2_pos       = np2;
    winner_valid = 1'b0;
    pos_valid    = 1'b1;
    t0           = cyc;
  endtask

  task automatic drive_drop(input logic [3:0] flag, input logic win,
                            input logic [3:0] np1, input logic [3:0] np2,
                            output int t1);
    @(posedge clk);
    #1;
    event_flag   = flag;
    winner_valid = win;
    p1_pos       = np1;
    p2_pos       = np2;
    pos_valid    = 1'b0;
    t1           = cyc;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; pos_valid = 1'b0; turn = 1'b0;
    p1_pos = 4'd2; p2_pos = 4'd12; event_flag = 4'd0; winner_valid = 1'b0;
    repeat (3) @(posedge clk);
    at_neg(cyc);
    total++; if (disp_p1_pos !== 4'd0) begin bad++; $display("FAIL rst_disp_p1: got %0d want 0", disp_p1_pos); end
    total++; if (disp_p2_pos !== 4'd0) begin bad++; $display("FAIL rst_disp_p2: got %0d want 0", disp_p2_pos); end
    total++; if (turn_done !== 1'b0) begin bad++; $display("FAIL rst_turn_done: got %b want 0", turn_done); end
    total++; if (anim_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", anim_busy); end
    total++; if (anim_player !== 1'b0) begin bad++; $display("FAIL rst_player: got %b want 0", anim_player); end
    total++; if (debug_state !== 3'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", debug_state); end
    @(posedge clk); #1; reset_n = 1'b1;
    at_neg(cyc + 2);
    total++; if (disp_p1_pos !== 4'd2) begin bad++; $display("FAIL resync_p1: got %0d want 2", disp_p1_pos); end
    total++; if (disp_p2_pos !== 4'd10) begin bad++; $display("FAIL resync_p2_clamp: got %0d want 10", disp_p2_pos); end
    @(posedge clk); #1; p1_pos = 4'd0; p2_pos = 4'd0;
    at_neg(cyc + 2);
  endtask

  // P1 0 -> 3; event_flag 1 on the drop gives no second pulse.
  task automatic test_fwd_move;
    int t0, t1;
    drive_rise(1'b0, 4'd3, 4'd0, t0);
    exp_q.push_back(t0 + 3*S + 2);
    at_neg(t0 + 1);
    total++; if (debug_state !== 3'd1 || anim_busy !== 1'b1) begin bad++; $display("FAIL fwd_state: got %0d/%b want 1/1", debug_state, anim_busy); end
    at_neg(t0 + 4);
    total++; if (disp_p1_pos !== 4'd0) begin bad++; $display("FAIL fwd_c4: got %0d want 0", disp_p1_pos); end
    for (int k = 1; k <= 3; k++) begin
      at_neg(t0 + k*S + 1);
      total++; if (disp_p1_pos !== 4'(k)) begin bad++; $display("FAIL fwd_step%0d: got %0d want %0d", k, disp_p1_pos, k); end
    end
    total++; if (disp_p2_pos !== 4'd0) begin bad++; $display("FAIL fwd_p2_still: got %0d want 0", disp_p2_pos); end
    at_neg(t0 + 3*S + 2);
    drive_drop(4'd1, 1'b0, 4'd3, 4'd0, t1);
    at_neg(t1 + 1);
    total++; if (debug_state !== 3'd0) begin bad++; $display("FAIL fwd_flag1_idle: got %0d want 0", debug_state); end
    at_neg(t1 + 10);
  endtask

  // P2 0 -> 3 then back to start.
  task automatic test_event_move;
    int t0, t1;
    drive_rise(1'b1, 4'd3, 4'd3, t0);
    exp_q.push_back(t0 + 3*S + 2);
    at_neg(t0 + 3*S + 2);
    total++; if (debug_state !== 3'd2) begin bad++; $display("FAIL evm_wait: got %0d want 2", debug_state); end
    drive_drop(4'd3, 1'b0, 4'd3, 4'd0, t1);
    exp_q.push_back(t1 + 3*S + 2);
    at_neg(t1 + 1);
    total++; if (debug_state !== 3'd3 || anim_player !== 1'b1) begin bad++; $display("FAIL evm_state: got %0d/%b want 3/1", debug_state, anim_player); end
    for (int k = 1; k <= 3; k++) begin
      at_neg(t1 + k*S + 1);
      total++; if (disp_p2_pos !== 4'(3 - k)) begin bad++; $display("FAIL evm_step%0d: got %0d want %0d", k, disp_p2_pos, 3 - k); end
    end
    total++; if (disp_p1_pos !== 4'd3) begin bad++; $display("FAIL evm_p1_still: got %0d want 3", disp_p1_pos); end
    at_neg(t1 + 3*S + 4);
  endtask

  // P1 3 -> 4 then a timed hold.
  task automatic test_event_hold;
    int t0, t1;
    drive_rise(1'b0, 4'd4, 4'd0, t0);
    exp_q.push_back(t0 + S + 2);
    at_neg(t0 + S + 2);
    drive_drop(4'd4, 1'b0, 4'd4, 4'd0, t1);
    exp_q.push_back(t1 + H + 1);
    at_neg(t1 + 1);
    total++; if (debug_state !== 3'd4) begin bad++; $display("FAIL hold_state: got %0d want 4", debug_state); end
    at_neg(t1 + H);
    total++; if (disp_p1_pos !== 4'd4 || anim_busy !== 1'b1) begin bad++; $display("FAIL hold_disp: got %0d/%b want 4/1", disp_p1_pos, anim_busy); end
    at_neg(t1 + H + 2);
    total++; if (anim_busy !== 1'b0) begin bad++; $display("FAIL hold_end_busy: got %b want 0", anim_busy); end
  endtask

  // P1 8 -> clamped 10 with winner; then a zero-length move.
  task automatic test_winner;
    int t0, t1;
    @(posedge clk); #1; p1_pos = 4'd8;
    at_neg(cyc + 2);
    total++; if (disp_p1_pos !== 4'd8) begin bad++; $display("FAIL win_pre: got %0d want 8", disp_p1_pos); end
    drive_rise(1'b0, 4'd12, 4'd0, t0);
    exp_q.push_back(t0 + 2*S + 2);
    at_neg(t0 + 2*S + 1);
    total++; if (disp_p1_pos !== 4'd10) begin bad++; $display("FAIL win_clamp: got %0d want 10", disp_p1_pos); end
    at_neg(t0 + 2*S + 2);
    drive_drop(4'd10, 1'b1, 4'd12, 4'd0, t1);
    at_neg(t1 + 1);
    total++; if (debug_state !== 3'd0) begin bad++; $display("FAIL win_idle: got %0d want 0", debug_state); end
    at_neg(t1 + 12);
    total++; if (disp_p1_pos !== 4'd10) begin bad++; $display("FAIL win_hold10: got %0d want 10", disp_p1_pos); end
    drive_rise(1'b0, 4'd12, 4'd0, t0);
    exp_q.push_back(t0 + 2);
    at_neg(t0 + 2);
    drive_drop(4'd1, 1'b0, 4'd12, 4'd0, t1);
    at_neg(t1 + 8);
    total++; if (debug_state !== 3'd0) begin bad++; $display("FAIL k0_idle: got %0d want 0", debug_state); end
  endtask

  // Reset during FWD_MOVE with pos_valid held high.
  task automatic test_reset_mid;
    int t0, t1;
    drive_rise(1'b1, 4'd12, 4'd3, t0);
    at_neg(t0 + S + 1);
    total++; if (disp_p2_pos !== 4'd1) begin bad++; $display("FAIL rm_step: got %0d want 1", disp_p2_pos); end
    at_neg(t0 + S + 2);
    #1 reset_n = 1'b0;
    #1;
    total++;
    if (disp_p1_pos !== 4'd0 || disp_p2_pos !== 4'd0 || turn_done !== 1'b0 ||
        anim_busy !== 1'b0 || anim_player !== 1'b0 || debug_state !== 3'd0) begin
      bad++;
      $display("FAIL rm_async: got p1=%0d p2=%0d td=%b busy=%b pl=%b st=%0d want all 0",
               disp_p1_pos, disp_p2_pos, turn_done, anim_busy, anim_player, debug_state);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    at_neg(cyc + 20);
    total++; if (debug_state !== 3'd0 || disp_p2_pos !== 4'd3 || disp_p1_pos !== 4'd10) begin bad++; $display("FAIL rm_after: got st=%0d p1=%0d p2=%0d want 0/10/3", debug_state, disp_p1_pos, disp_p2_pos); end
    drive_drop(4'd1, 1'b0, 4'd12, 4'd3, t1);
    at_neg(t1 + 2);
    drive_rise(1'b1, 4'd12, 4'd3, t0);
    exp_q.push_back(t0 + 2);
    at_neg(t0 + 2);
    drive_drop(4'd1, 1'b0, 4'd12, 4'd3, t1);
    at_neg(t1 + 4);
  endtask

  initial begin
    test_reset();
    test_fwd_move();
    test_event_move();
    test_event_hold();
    test_winner();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_pulses: got %0d outstanding want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/player_move_animator.md
# player_move_animator

UI-side responder for the game controller's position handshake. It watches `pos_valid` and the player positions, then steps each player's displayed tile one square at a time toward the committed position. It also plays the post-landing event (move-back animation or timed hold) and returns a single-cycle `turn_done` to release the controller. It sits between the game logic controller and the board renderer, on the same clock as both.

## Interface
- `STEP_CYCLES`, default 25_000_000: cycles per one-tile step (0.25 s at 100 MHz); benches override to small values.
- `EVENT_HOLD_CYCLES`, default 50_000_000: hold time for a non-moving event tile.
- `MAX_POS`, default 10: goal tile; targets are clamped to this value.
- `clk  input  1`: system clock. One clock domain only.
- `reset_n  input  1`: asynchronous, active-low reset.
- `pos_valid  input  1`: level from the controller; high from the cycle after the position update until the cycle after `turn_done` is accepted.
- `turn  input  1`: mover identity, 0 = player 1, 1 = player 2.
- `p1_pos`, `p2_pos  input  4`: committed positions.
- `event_flag  input  4`: landing event code: 1 = none, 2/4/6/8 = hold, 3 = back to start, 10 = win.
- `winner_valid  input  1`: game over.
- `disp_p1_pos`, `disp_p2_pos  output  4`: displayed positions sent to the renderer.
- `turn_done  output  1`: single-cycle completion pulse.
- `anim_busy  output  1`: high in every state except IDLE.
- `anim_player  output  1`: player latched for the current animation.
- `debug_state  output  3`: current state encoding.

## Operation
- All outputs are registered. On reset every output is 0, state is IDLE, and both step and hold counters are 0.
- `target` = `min(pos of anim_player, MAX_POS)`.
- The block detects a rising edge of `pos_valid` from a registered copy, `pv_d`. The edge is acted on only in IDLE and ignored in every other state.
- **IDLE**
  - On a `pos_valid` rise: latch `anim_player` ← `turn`, clear the step counter, go to FWD_MOVE.
- **FWD_MOVE**
  - If displayed position == `target`: pulse `turn_done`, go to WAIT_DROP.
  - Otherwise: count; when the counter reaches `STEP_CYCLES-1`, wrap it to 0 and move the displayed position one tile toward `target` (+1 if below, -1 if above).
- **WAIT_DROP**
  - Wait for `pos_valid` == 0. In that same cycle, `event_flag`, `winner_valid` and the positions are already the fresh post-check values.
  - If `winner_valid`, or `event_flag` ∈ {1, 10}: go to IDLE with no pulse.
  - Else if displayed position ≠ `target`: clear the counter, go to EVT_MOVE.
  - Else: clear the hold counter, go to EVT_HOLD.
- **EVT_MOVE**
  - Same stepping as FWD_MOVE, backward allowed.
  - On arrival: pulse `turn_done`, go to IDLE.
- **EVT_HOLD**
  - When the hold counter reaches `EVENT_HOLD_CYCLES-1`: pulse `turn_done`, go to IDLE.
- Only the displayed position of `anim_player` changes during an animation.
- In IDLE, each displayed position is overwritten with its clamped committed position every cycle. This resyncs the display after reset or a controller restart.
- Step counter is 32 bits.
- `MAX_POS` and all positions fit in 4 bits; no arithmetic wraps. A -1 step is never applied at 0 because the target is ≥ 0.
- A `reset_n` assertion mid-animation returns the block to the reset values immediately, with no `turn_done` pulse.

## Timing
- Cycle 0 is the first cycle with `pos_valid` = 1. For a move of k tiles:
  - The displayed position changes at cycles S+1, 2S+1, …, kS+1, where S = `STEP_CYCLES`.
  - `turn_done` is high in cycle kS+2 only.
  - For k = 0 (already at goal), `turn_done` is high at cycle 2.
- Event path: cycle 0 is the first cycle with `pos_valid` = 0 in WAIT_DROP.
  - Hold: `turn_done` at cycle `EVENT_HOLD_CYCLES`+1.
  - Move-back of k tiles: `turn_done` at cycle kS+2.
- `turn_done` is never high on two consecutive cycles.
- At most two pulses per handshake: one forward, one event.

## Test plan
- S=4. P1 goes 0→3 (`turn`=0, `pos_valid` rises) → `disp_p1_pos` reads 1, 2, 3 at cycles 5, 9, 13. `turn_done` is high at cycle 14 only. `disp_p2_pos` is unchanged.
- S=4. P2 lands on 3, then `event_flag`=3 with `p2_pos`=0 after the `pos_valid` drop → forward pulse, then `disp_p2_pos` steps 3→2→1→0 and a second `turn_done` is high at drop+14.
- `EVENT_HOLD_CYCLES`=8. P1 lands on 4 with `event_flag`=4 → after the drop, `turn_done` is high at cycle 9. Display stays at 4.
- P1 8→10 with `winner_valid`=1 on the drop → one forward `turn_done` only, then IDLE. `event_flag`=1 also produces no second pulse.
- Assert `reset_n`=0 mid-FWD_MOVE → all outputs are 0 on the same cycle and no `turn_done` appears. After release with `pos_valid` held high, no animation starts until `pos_valid` falls and rises again.
